// File: rtl/nibble_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | testpackage : shared constants and state encoding for nibble_tx      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package testpackage;

   localparam logic [3:0] ELG = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_fifo : power-of-two FIFO with occupancy count, full/empty     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module nibble_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     ck,
   input  logic                     arst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wrData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int c_ptrW = $clog2(DEPTH);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [c_ptrW-1:0] r_wrPtr;
   logic [c_ptrW-1:0] r_rdPtr;
   logic [c_ptrW:0]   r_count;
   logic              w_doPush;
   logic              w_doPop;

   assign full     = (r_count == (c_ptrW + 1)'(DEPTH));
   assign empty    = (r_count == '0);
   // A full FIFO refuses the push even when a pop frees a slot this cycle
   assign w_doPush = push && !full;
   assign w_doPop  = pop && !empty;

   always_ff @(posedge ck or negedge arst_n) begin
      if (!arst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge ck) begin
      if (w_doPush) r_mem[r_wrPtr] <= wrData;
   end

   assign rdData = r_mem[r_rdPtr];
   assign count  = r_count;

endmodule
`default_nettype wire

// File: rtl/nibble_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_tx : FIFO-buffered serial framer (start, data LSB first, stop)|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module nibble_tx
   import testpackage::*;
#(
   parameter int WIDTH        = 4,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 2,
   parameter int STOP_BITS    = 1
) (
   input  logic                   ck,
   input  logic                   arst_n,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   output logic                   tx_sd,
   output logic                   tx_busy,
   output logic [WIDTH-1:0]       last_val,
   output logic [$clog2(DEPTH):0] fifo_cnt
);

   localparam int c_cntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int c_idxW = $clog2(WIDTH + STOP_BITS);

   tx_state_t          r_state;
   logic [c_cntW-1:0]  r_bitCnt;
   logic [c_idxW-1:0]  r_bitIdx;
   logic [WIDTH-1:0]   r_shift;
   logic               r_txSd;
   logic               r_txBusy;
   logic [WIDTH-1:0]   r_lastVal;

   tx_state_t          w_nextState;
   logic [c_cntW-1:0]  w_nextBitCnt;
   logic [c_idxW-1:0]  w_nextBitIdx;
   logic [WIDTH-1:0]   w_nextShift;
   logic               w_nextTxSd;
   logic               w_pop;
   logic               w_bitDone;
   logic [WIDTH-1:0]   w_head;
   logic               w_full;
   logic               w_empty;

   nibble_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ck     (ck),
      .arst_n (arst_n),
      .push   (in_valid),
      .wrData (in_data),
      .pop    (w_pop),
      .rdData (w_head),
      .count  (fifo_cnt),
      .full   (w_full),
      .empty  (w_empty)
   );

   assign w_bitDone = (r_bitCnt == c_cntW'(CLKS_PER_BIT - 1));

   always_comb begin
      w_nextState  = r_state;
      w_nextBitCnt = r_bitCnt;
      w_nextBitIdx = r_bitIdx;
      w_nextShift  = r_shift;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_nextShift  = w_head;
               w_nextBitCnt = '0;
               w_nextState  = START;
            end
         end
         START: begin
            if (w_bitDone) begin
               w_nextBitCnt = '0;
               w_nextBitIdx = '0;
               w_nextState  = DATA;
            end else begin
               w_nextBitCnt = r_bitCnt + 1'b1;
            end
         end
         DATA: begin
            if (w_bitDone) begin
               w_nextBitCnt = '0;
               if (r_bitIdx == c_idxW'(WIDTH - 1)) begin
                  w_nextBitIdx = '0;
                  w_nextState  = STOP;
               end else begin
                  w_nextBitIdx = r_bitIdx + 1'b1;
                  w_nextShift  = r_shift >> 1;
               end
            end else begin
               w_nextBitCnt = r_bitCnt + 1'b1;
            end
         end
         STOP: begin
            if (w_bitDone) begin
               w_nextBitCnt = '0;
               if (r_bitIdx == c_idxW'(STOP_BITS - 1)) begin
                  w_nextBitIdx = '0;
                  // Chain straight into the next frame when data is waiting
                  if (!w_empty) begin
                     w_pop       = 1'b1;
                     w_nextShift = w_head;
                     w_nextState = START;
                  end else begin
                     w_nextState = IDLE;
                  end
               end else begin
                  w_nextBitIdx = r_bitIdx + 1'b1;
               end
            end else begin
               w_nextBitCnt = r_bitCnt + 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase

      case (w_nextState)
         START:   w_nextTxSd = 1'b0;
         DATA:    w_nextTxSd = w_nextShift[0];
         default: w_nextTxSd = 1'b1;
      endcase
   end

   always_ff @(posedge ck or negedge arst_n) begin
      if (!arst_n) begin
         r_state   <= IDLE;
         r_bitCnt  <= '0;
         r_bitIdx  <= '0;
         r_shift   <= '0;
         r_txSd    <= 1'b1;
         r_txBusy  <= 1'b0;
         r_lastVal <= WIDTH'(ELG);
      end else begin
         r_state  <= w_nextState;
         r_bitCnt <= w_nextBitCnt;
         r_bitIdx <= w_nextBitIdx;
         r_shift  <= w_nextShift;
         r_txSd   <= w_nextTxSd;
         r_txBusy <= (w_nextState != IDLE);
         if (w_pop) r_lastVal <= w_head;
      end
   end

   assign in_ready = !w_full;
   assign tx_sd    = r_txSd;
   assign tx_busy  = r_txBusy;
   assign last_val = r_lastVal;

endmodule
`default_nettype wire

// File: tb/tb_nibble_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nibble_tx : directed self-checking bench for nibble_tx            |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_nibble_tx;

   logic       ck;
   logic       arst_n;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       tx_sd;
   logic       tx_busy;
   logic [3:0] last_val;
   logic [2:0] fifo_cnt;

   int nChecks = 0;
   int nErrors = 0;

   int   busyCycles = 0;
   int   busyRises  = 0;
   logic prevBusy   = 1'b0;

   logic [3:0] rxQ [$];
   int         rxIdx    = 0;
   logic [3:0] rxBits   = '0;
   int         frameErr = 0;

   nibble_tx dut (
      .ck       (ck),
      .arst_n   (arst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .tx_sd    (tx_sd),
      .tx_busy  (tx_busy),
      .last_val (last_val),
      .fifo_cnt (fifo_cnt)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Line receiver: 12 samples per frame, one per falling edge
   always @(negedge ck or negedge arst_n) begin
      if (!arst_n) begin
         rxIdx  = 0;
         rxBits = '0;
      end else if (rxIdx == 0) begin
         if (tx_sd === 1'b0) rxIdx = 1;
      end else begin
         if (rxIdx >= 2 && rxIdx <= 9 && (rxIdx % 2) == 0) rxBits[(rxIdx - 2) / 2] = tx_sd;
         if (rxIdx >= 10 && tx_sd !== 1'b1) frameErr++;
         if (rxIdx == 11) begin
            rxQ.push_back(rxBits);
            rxIdx = 0;
         end else begin
            rxIdx++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stepMon();
      @(posedge ck);
      #1;
      if (tx_busy === 1'b1) busyCycles++;
      if (tx_busy === 1'b1 && prevBusy === 1'b0) busyRises++;
      prevBusy = tx_busy;
   endtask

   task automatic drain(input string tag, input int maxCyc);
      int n = 0;
      while ((tx_busy !== 1'b0 || fifo_cnt !== 3'd0) && n < maxCyc) begin
         stepMon();
         n++;
      end
      chk(tag, {31'd0, (tx_busy === 1'b0 && fifo_cnt === 3'd0)}, 32'd1);
   endtask

   task automatic chkRx(input string tag, input int idx, input logic [3:0] exp);
      if (rxQ.size() > idx) chk($sformatf("%s[%0d]", tag, idx), {28'd0, rxQ[idx]}, {28'd0, exp});
      else chk($sformatf("%s[%0d]_missing", tag, idx), 32'd0, 32'd1);
   endtask

   initial begin
      logic [11:0] expSeq;
      logic [3:0]  btb [3];
      logic [3:0]  val;
      logic        wasReady;
      int          n;
      int          lows;

      arst_n   = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge ck);
      #1;
      chk("rst_held_tx_sd", {31'd0, tx_sd}, 32'd1);
      arst_n = 1'b1;
      stepMon();
      chk("rst_tx_sd",    {31'd0, tx_sd},    32'd1);
      chk("rst_tx_busy",  {31'd0, tx_busy},  32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
      chk("rst_last_val", {28'd0, last_val}, 32'd9);

      // Single nibble 0xA
      in_valid = 1'b1;
      in_data  = 4'hA;
      stepMon();
      in_valid = 1'b0;
      chk("a_cnt_after_push", {29'd0, fifo_cnt}, 32'd1);
      chk("a_sd_before_pop",  {31'd0, tx_sd},    32'd1);
      expSeq = 12'hF30;
      for (int i = 0; i < 12; i++) begin
         stepMon();
         chk($sformatf("a_sd_%0d", i),   {31'd0, tx_sd},   {31'd0, expSeq[i]});
         chk($sformatf("a_busy_%0d", i), {31'd0, tx_busy}, 32'd1);
      end
      stepMon();
      chk("a_busy_end",  {31'd0, tx_busy},  32'd0);
      chk("a_sd_end",    {31'd0, tx_sd},    32'd1);
      chk("a_last_val",  {28'd0, last_val}, 32'hA);
      chk("a_rx_count",  rxQ.size(),        32'd1);
      chkRx("a_rx", 0, 4'hA);

      // Back-to-back 0x3, 0xC, 0x5
      rxQ.delete();
      busyCycles = 0;
      busyRises  = 0;
      btb[0] = 4'h3; btb[1] = 4'hC; btb[2] = 4'h5;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = btb[i];
         stepMon();
      end
      in_valid = 1'b0;
      drain("btb_drain", 80);
      chk("btb_busy_cycles", busyCycles,        32'd36);
      chk("btb_busy_rises",  busyRises,         32'd1);
      chk("btb_last_val",    {28'd0, last_val}, 32'h5);
      chk("btb_rx_count",    rxQ.size(),        32'd3);
      for (int i = 0; i < 3; i++) chkRx("btb_rx", i, btb[i]);

      // Full FIFO: producer ignores in_ready
      rxQ.delete();
      in_valid = 1'b1;
      in_data = 4'h1; stepMon(); chk("full_cnt1", {29'd0, fifo_cnt}, 32'd1);
      in_data = 4'h2; stepMon(); chk("full_cnt2", {29'd0, fifo_cnt}, 32'd1);
      in_data = 4'h3; stepMon(); chk("full_cnt3", {29'd0, fifo_cnt}, 32'd2);
      in_data = 4'h4; stepMon(); chk("full_cnt4", {29'd0, fifo_cnt}, 32'd3);
      in_data = 4'h5; stepMon(); chk("full_cnt5", {29'd0, fifo_cnt}, 32'd4);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      in_data = 4'h6; stepMon(); chk("full_reject", {29'd0, fifo_cnt}, 32'd4);
      n = 0;
      while (fifo_cnt === 3'd4 && n < 20) begin
         stepMon();
         n++;
      end
      chk("full_push_on_pop", {29'd0, fifo_cnt}, 32'd3);
      in_valid = 1'b0;
      drain("full_drain", 120);
      chk("full_rx_count", rxQ.size(), 32'd5);
      for (int i = 0; i < 5; i++) chkRx("full_rx", i, 4'(i + 1));
      chk("frame_errors", frameErr, 32'd0);

      // Reset during DATA of 0xF with one more entry queued
      rxQ.delete();
      in_valid = 1'b1;
      in_data = 4'hF; stepMon();
      in_data = 4'h7; stepMon();
      in_valid = 1'b0;
      repeat (4) stepMon();
      chk("mid_busy_before", {31'd0, tx_busy},  32'd1);
      chk("mid_cnt_before",  {29'd0, fifo_cnt}, 32'd1);
      chk("mid_last_val",    {28'd0, last_val}, 32'hF);
      arst_n = 1'b0;
      #2;
      chk("mid_rst_sd",       {31'd0, tx_sd},    32'd1);
      chk("mid_rst_busy",     {31'd0, tx_busy},  32'd0);
      chk("mid_rst_cnt",      {29'd0, fifo_cnt}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_last_val", {28'd0, last_val}, 32'd9);
      repeat (2) stepMon();
      arst_n = 1'b1;
      busyCycles = 0;
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         stepMon();
         if (tx_sd !== 1'b1) lows++;
      end
      chk("mid_after_lows", lows,                32'd0);
      chk("mid_after_busy", busyCycles,          32'd0);
      chk("mid_after_cnt",  {29'd0, fifo_cnt},   32'd0);
      chk("mid_after_rx",   rxQ.size(),          32'd0);

      // Wrap-around: 0x0..0x9 with a ready-respecting producer
      rxQ.delete();
      val      = 4'h0;
      in_valid = 1'b1;
      in_data  = val;
      n = 0;
      while (in_valid && n < 300) begin
         wasReady = in_ready;
         stepMon();
         n++;
         if (wasReady) begin
            val = val + 4'd1;
            if (val == 4'd10) in_valid = 1'b0;
            else in_data = val;
         end
      end
      chk("wrap_all_pushed", {31'd0, in_valid}, 32'd0);
      drain("wrap_drain", 200);
      chk("wrap_rx_count", rxQ.size(),        32'd10);
      for (int i = 0; i < 10; i++) chkRx("wrap_rx", i, 4'(i));
      chk("wrap_last_val", {28'd0, last_val}, 32'h9);
      chk("wrap_frame_err", frameErr,         32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
`default_nettype wire
